// File: rtl/debug_display.sv
// rtl/debug_display.sv - debug channel snapshot shown one page at a time on active-low 7-seg digits
module debug_display #(
    parameter int  NUM_DIGITS = 4,
    parameter int  NUM_SRC    = 4,
    parameter int  PAGE_TICKS = 50_000_000,
    parameter int  LZ_BLANK   = 0,
    localparam int SEL_W      = $clog2(NUM_SRC),
    localparam int PAGES      = 32 / (4 * NUM_DIGITS),
    localparam int PG_W       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_SRC*32-1:0]   i_src_data,
    input  logic [SEL_W-1:0]        i_src_sel,
    input  logic [1:0]              i_mode,
    input  logic [PG_W-1:0]         i_page_sel,
    input  logic                    i_tick_in,
    output logic [NUM_DIGITS*8-1:0] o_seg_n,
    output logic [PG_W-1:0]         o_page_out
);

    localparam int       PAGE_BITS   = 4 * NUM_DIGITS;
    localparam int       TMR_W       = $clog2(PAGE_TICKS);
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_FREEZE = 2'b10;

    logic [31:0]           r_snap;
    logic [PG_W-1:0]       r_page;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_was_auto;
    logic                  r_hb;
    logic                  r_tick_s0;
    logic                  r_tick_q0;
    logic                  r_tick_q1;

    logic [31:0]           w_chan;
    logic                  w_auto;
    logic                  w_freeze;
    logic [PG_W-1:0]       w_page_sel;
    logic                  w_hb_next;
    logic [PAGE_BITS-1:0]  w_page_bits;
    logic [NUM_DIGITS*8-1:0] w_seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        w_chan = i_src_data[31:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (i_src_sel == SEL_W'(k)) begin
                w_chan = i_src_data[32*k +: 32];
            end
        end
    end

    assign w_auto     = (i_mode == MODE_AUTO);
    assign w_freeze   = (i_mode == MODE_FREEZE);
    assign w_page_sel = (32'(i_page_sel) < PAGES) ? i_page_sel : '0;

    // dp is registered from the next hb value so it moves in the same edge as hb.
    assign w_hb_next   = r_hb ^ (r_tick_q0 & ~r_tick_q1);
    assign w_page_bits = PAGE_BITS'(r_snap >> (PAGE_BITS * 32'(r_page)));

    always_comb begin
        logic       v_lead;
        logic [3:0] v_nib;
        w_seg_next = '1;
        v_lead     = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            v_nib = w_page_bits[4*d +: 4];
            if ((LZ_BLANK != 0) && v_lead && (v_nib == 4'h0) && (d != 0)) begin
                w_seg_next[8*d +: 7] = 7'h7F;
            end else begin
                w_seg_next[8*d +: 7] = hex7(v_nib);
                v_lead               = 1'b0;
            end
        end
        w_seg_next[7] = ~w_hb_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_snap     <= '0;
            r_page     <= '0;
            r_timer    <= '0;
            r_was_auto <= 1'b0;
            r_hb       <= 1'b0;
            r_tick_s0  <= 1'b0;
            r_tick_q0  <= 1'b0;
            r_tick_q1  <= 1'b0;
            o_seg_n    <= '1;
            o_page_out <= '0;
        end else begin
            if (!w_freeze) begin
                r_snap <= w_chan;
            end

            r_was_auto <= w_auto;
            if (w_auto) begin
                if (!r_was_auto) begin
                    r_page  <= '0;
                    r_timer <= '0;
                end else if (r_timer == TMR_W'(PAGE_TICKS - 1)) begin
                    r_timer <= '0;
                    r_page  <= (r_page == PG_W'(PAGES - 1)) ? '0 : r_page + PG_W'(1);
                end else begin
                    r_timer <= r_timer + TMR_W'(1);
                end
            end else begin
                r_timer <= '0;
                r_page  <= w_page_sel;
            end

            r_tick_s0  <= i_tick_in;
            r_tick_q0  <= r_tick_s0;
            r_tick_q1  <= r_tick_q0;
            r_hb       <= w_hb_next;

            o_seg_n    <= w_seg_next;
            o_page_out <= r_page;
        end
    end

endmodule

// File: tb/tb_debug_display.sv
// tb/tb_debug_display.sv - directed table-driven bench for debug_display
module tb_debug_display;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  ch [4];
    logic [127:0] src_data;
    logic [95:0]  src_lz;
    logic [1:0]   src_sel;
    logic [1:0]   mode;
    logic         page_sel;
    logic         tick_in;
    logic [31:0]  seg_a, seg_b;
    logic         page_a, page_b;

    int checks = 0;
    int errors = 0;

    assign src_data = {ch[3], ch[2], ch[1], ch[0]};
    assign src_lz   = src_data[95:0];

    always #5 clk = ~clk;

    debug_display #(.NUM_DIGITS(4), .NUM_SRC(4), .PAGE_TICKS(4), .LZ_BLANK(0)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_src_data(src_data), .i_src_sel(src_sel),
        .i_mode(mode), .i_page_sel(page_sel), .i_tick_in(tick_in),
        .o_seg_n(seg_a), .o_page_out(page_a));

    debug_display #(.NUM_DIGITS(4), .NUM_SRC(3), .PAGE_TICKS(4), .LZ_BLANK(1)) u_lz (
        .i_clk(clk), .i_reset(reset), .i_src_data(src_lz), .i_src_sel(src_sel),
        .i_mode(mode), .i_page_sel(page_sel), .i_tick_in(tick_in),
        .o_seg_n(seg_b), .o_page_out(page_b));

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic        page;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic       exp_auto [9];
        logic       exp_rst  [6];
        logic       dp_exp;

        vecs[0] = '{2'b00, 2'd2, 1'b0, 32'h8883C6A1, 32'h8883C6A1};
        vecs[1] = '{2'b00, 2'd2, 1'b1, 32'hF9A4B099, 32'hF9A4B099};
        vecs[2] = '{2'b00, 2'd0, 1'b0, 32'hC0C0F8C0, 32'hFFFFF8C0};
        vecs[3] = '{2'b11, 2'd0, 1'b1, 32'hC0C0C0C0, 32'hFFFFFFC0};
        vecs[4] = '{2'b00, 2'd1, 1'b0, 32'hC086C0C0, 32'hFF86C0C0};
        vecs[5] = '{2'b11, 2'd1, 1'b1, 32'hC0C0C092, 32'hFFFFFF92};
        vecs[6] = '{2'b00, 2'd3, 1'b0, 32'h8EC0C08E, 32'hFFFFF8C0};
        vecs[7] = '{2'b00, 2'd3, 1'b1, 32'hC0829080, 32'hFFFFFFC0};
        exp_auto = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_rst  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held 3 cycles with arbitrary inputs
        reset = 1'b1; tick_in = 1'b0; mode = 2'b01; page_sel = 1'b1; src_sel = 2'd2;
        ch[0] = 32'h0000_0070; ch[1] = 32'h0005_0E00; ch[2] = 32'h1234_ABCD; ch[3] = 32'h0698_F00F;
        repeat (3) step();
        check("reset_seg_a", seg_a, 32'hFFFFFFFF);
        check("reset_seg_b", seg_b, 32'hFFFFFFFF);
        check("reset_page", 32'(page_a), 32'd0);

        reset = 1'b0; mode = 2'b00; page_sel = 1'b0;
        step();
        check("release_edge1", seg_a, 32'hC0C0C0C0);
        step();
        check("release_edge2", seg_a, 32'h8883C6A1);

        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode; src_sel = vecs[i].sel; page_sel = vecs[i].page;
            step();
            step();
            check($sformatf("vec%0d_seg_a", i), seg_a, vecs[i].exp_a);
            check($sformatf("vec%0d_seg_b", i), seg_b, vecs[i].exp_b);
            check($sformatf("vec%0d_page", i), 32'(page_a), 32'(vecs[i].page));
        end

        // Freeze: entry cycle does not capture, page_sel still honoured
        mode = 2'b00; src_sel = 2'd2; page_sel = 1'b0; ch[2] = 32'h0000_00FF;
        step(); step();
        check("frz_pre", seg_a, 32'hC0C08E8E);
        mode = 2'b10; ch[2] = 32'hFFFF_FFFF; src_sel = 2'd0;
        repeat (3) step();
        check("frz_hold", seg_a, 32'hC0C08E8E);
        page_sel = 1'b1;
        step(); step();
        check("frz_page1", seg_a, 32'hC0C0C0C0);
        check("frz_page1_out", 32'(page_a), 32'd1);
        page_sel = 1'b0;
        step(); step();
        mode = 2'b00; src_sel = 2'd2;
        step();
        check("frz_exit_e1", seg_a, 32'hC0C08E8E);
        step();
        check("frz_exit_e2", seg_a, 32'h8E8E8E8E);
        ch[2] = 32'h1234_ABCD;

        // Auto cycling from a manual page 1
        mode = 2'b00; page_sel = 1'b1;
        step(); step();
        mode = 2'b01;
        step();
        check("auto_entry_lag", 32'(page_a), 32'd1);
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("auto_seq%0d", i), 32'(page_a), 32'(exp_auto[i]));
        end

        // Leave auto at timer 2: page follows page_sel
        mode = 2'b00; page_sel = 1'b1;
        step(); step();
        mode = 2'b01;
        repeat (3) step();
        mode = 2'b00;
        step();
        check("auto_leave_e3", 32'(page_a), 32'd0);
        step();
        check("auto_leave_e4", 32'(page_a), 32'd1);

        // Mode change on the wrap cycle: manual wins over the increment
        mode = 2'b01;
        repeat (4) step();
        mode = 2'b00; page_sel = 1'b0;
        step(); step();
        check("wrap_vs_mode", 32'(page_a), 32'd0);

        // Reset mid-auto, then mode=01 is a fresh entry
        mode = 2'b01;
        repeat (6) step();
        check("pre_reset_page1", 32'(page_a), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midauto_reset_seg", seg_a, 32'hFFFFFFFF);
        check("midauto_reset_page", 32'(page_a), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("rst_auto_seq%0d", i), 32'(page_a), 32'(exp_rst[i]));
        end

        // Heartbeat dp: 3 rising edges, 3-clock latency each
        mode = 2'b00; page_sel = 1'b0; src_sel = 2'd2;
        step(); step(); step();
        dp_exp = 1'b1;
        check("dp_initial", 32'(seg_a[7]), 32'(dp_exp));
        for (int p = 0; p < 3; p++) begin
            tick_in = 1'b1;
            step();
            check($sformatf("dp%0d_e1", p), 32'(seg_a[7]), 32'(dp_exp));
            step();
            check($sformatf("dp%0d_e2", p), 32'(seg_a[7]), 32'(dp_exp));
            step();
            dp_exp = ~dp_exp;
            check($sformatf("dp%0d_e3", p), 32'(seg_a[7]), 32'(dp_exp));
            check($sformatf("dp%0d_lz", p), 32'(seg_b[7]), 32'(dp_exp));
            tick_in = 1'b0;
            repeat (4) step();
        end
        check("dp_others", 32'({seg_a[31], seg_a[23], seg_a[15]}), 32'd7);
        check("dp_final_seg", seg_a, 32'h8883C621);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
